// File: rtl/pending_request_latch.sv
// Request synchroniser, sticky edge capture and one-at-a-time grant offer
// feeding a 4-input priority encoder.
module pending_request_latch #(
   parameter int SYNC_STAGES = 2,
   parameter bit EDGE_MODE   = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] req_in,
   output logic [3:0] D,
   input  logic [1:0] Y,
   input  logic       V,
   output logic       grant_valid,
   output logic [1:0] grant_idx,
   input  logic       grant_ready,
   output logic [3:0] overflow,
   input  logic       clr_ovf
);

   typedef enum logic {IDLE, OFFER} state_t;

   state_t     state, state_nx;
   logic [1:0] idx_nx;
   logic [3:0] sync_q [SYNC_STAGES];
   logic [3:0] s, s_d, edge_det;
   logic [3:0] clr_mask;
   logic [3:0] d_nx, ovf_nx;
   logic       handshake;

   assign s         = sync_q[SYNC_STAGES-1];
   assign edge_det  = s & ~s_d;
   assign handshake = (state == OFFER) && grant_ready;
   assign clr_mask  = handshake ? (4'b0001 << grant_idx) : 4'b0000;

   assign grant_valid = (state == OFFER);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++)
            sync_q[i] <= '0;
         s_d <= '0;
      end else begin
         sync_q[0] <= req_in;
         for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
         s_d <= s;
      end
   end

   // Set beats clear, so an edge landing on its own handshake stays pending.
   always_comb begin
      d_nx   = s;
      ovf_nx = '0;
      if (EDGE_MODE) begin
         d_nx   = (D & ~clr_mask) | edge_det;
         ovf_nx = clr_ovf ? '0 : overflow;
         ovf_nx = ovf_nx | (edge_det & D & ~clr_mask);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         D        <= '0;
         overflow <= '0;
      end else begin
         D        <= d_nx;
         overflow <= ovf_nx;
      end
   end

   always_comb begin
      state_nx = state;
      idx_nx   = grant_idx;
      unique case (state)
         IDLE: begin
            if (V) begin
               state_nx = OFFER;
               idx_nx   = Y;
            end
         end
         OFFER: begin
            if (grant_ready)
               state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         grant_idx <= '0;
      end else begin
         state     <= state_nx;
         grant_idx <= idx_nx;
      end
   end

endmodule

// File: tb/tb_pending_request_latch.sv
// Directed bench for pending_request_latch with a behavioural
// priority encoder closing the D -> Y/V loop.
module tb_pending_request_latch;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] req_in;
   logic [3:0] D;
   logic [1:0] Y;
   logic       V;
   logic       grant_valid;
   logic [1:0] grant_idx;
   logic       grant_ready;
   logic [3:0] overflow;
   logic       clr_ovf;

   int checks = 0;
   int errors = 0;

   pending_request_latch #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .req_in(req_in), .D(D),
      .Y(Y), .V(V), .grant_valid(grant_valid), .grant_idx(grant_idx),
      .grant_ready(grant_ready), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   always_comb begin
      V = |D;
      Y = 2'd0;
      if (D[3])      Y = 2'd3;
      else if (D[2]) Y = 2'd2;
      else if (D[1]) Y = 2'd1;
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_d(input string nm, input logic [3:0] exp);
      checks++;
      if (D !== exp) begin
         errors++;
         $display("FAIL %s D got %b want %b", nm, D, exp);
      end
   endtask

   task automatic chk_g(input string nm, input logic gv, input logic [1:0] gi);
      checks++;
      if (grant_valid !== gv || (gv && grant_idx !== gi)) begin
         errors++;
         $display("FAIL %s grant got %b/%0d want %b/%0d",
                  nm, grant_valid, grant_idx, gv, gi);
      end
   endtask

   task automatic chk_o(input string nm, input logic [3:0] exp);
      checks++;
      if (overflow !== exp) begin
         errors++;
         $display("FAIL %s overflow got %b want %b", nm, overflow, exp);
      end
   endtask

   task automatic flush();
      req_in      = 4'b0000;
      grant_ready = 1'b0;
      clr_ovf     = 1'b0;
      step(4);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req_in = 4'b0000;
      grant_ready = 1'b0; clr_ovf = 1'b0;
      step(2);
      chk_d("reset", 4'b0000);
      chk_o("reset", 4'b0000);
      checks++;
      if (grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
         errors++;
         $display("FAIL reset grant got %b/%0d want 0/0", grant_valid, grant_idx);
      end
      reset_n = 1'b1;
      step(1);
   endtask

   task automatic test_single();
      req_in = 4'b0001;
      step(2);
      chk_d("single_lat", 4'b0000);
      step(1);
      chk_d("single_set", 4'b0001);
      chk_g("single_nogv", 1'b0, 2'd0);
      step(1);
      chk_g("single_offer", 1'b1, 2'd0);
      grant_ready = 1'b1;
      step(1);
      chk_d("single_clr", 4'b0000);
      chk_g("single_done", 1'b0, 2'd0);
      flush();
   endtask

   task automatic test_priority_drain();
      logic [3:0] exp_d;
      req_in = 4'b1111; grant_ready = 1'b1;
      step(3);
      chk_d("drain_set", 4'b1111);
      exp_d = 4'b1111;
      for (int i = 3; i >= 0; i--) begin
         step(1);
         chk_g("drain_offer", 1'b1, 2'(i));
         step(1);
         exp_d[i] = 1'b0;
         chk_d("drain_clr", exp_d);
         chk_g("drain_gap", 1'b0, 2'd0);
      end
      checks++;
      if (V !== 1'b0) begin
         errors++;
         $display("FAIL drain_v got %b want 0", V);
      end
      chk_o("drain_ovf", 4'b0000);
      flush();
   endtask

   task automatic test_backpressure();
      req_in = 4'b0010;
      step(4);
      chk_g("bp_offer", 1'b1, 2'd1);
      req_in = 4'b1010;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk_g("bp_hold", 1'b1, 2'd1);
      end
      chk_d("bp_both", 4'b1010);
      grant_ready = 1'b1;
      step(1);
      chk_d("bp_acc", 4'b1000);
      grant_ready = 1'b0;
      step(1);
      chk_g("bp_next", 1'b1, 2'd3);
      grant_ready = 1'b1;
      step(1);
      chk_d("bp_empty", 4'b0000);
      flush();
   endtask

   task automatic test_overflow();
      req_in = 4'b0100;
      step(4);
      chk_g("ovf_offer", 1'b1, 2'd2);
      req_in = 4'b0000;
      step(1);
      req_in = 4'b0100;
      step(2);
      chk_o("ovf_pre", 4'b0000);
      step(1);
      chk_o("ovf_set", 4'b0100);
      chk_d("ovf_d", 4'b0100);
      chk_g("ovf_hold", 1'b1, 2'd2);
      clr_ovf = 1'b1;
      step(1);
      chk_o("ovf_clr", 4'b0000);
      clr_ovf = 1'b0;
      grant_ready = 1'b1;
      step(1);
      chk_d("ovf_acc", 4'b0000);
      flush();
   endtask

   task automatic test_collision();
      req_in = 4'b0010;
      step(4);
      chk_g("col_offer", 1'b1, 2'd1);
      req_in = 4'b0000;
      step(3);
      req_in = 4'b0010;
      step(2);
      grant_ready = 1'b1;
      step(1);
      chk_d("col_keep", 4'b0010);
      chk_o("col_ovf", 4'b0000);
      chk_g("col_gap", 1'b0, 2'd0);
      grant_ready = 1'b0;
      step(1);
      chk_g("col_again", 1'b1, 2'd1);
      grant_ready = 1'b1;
      step(1);
      chk_d("col_done", 4'b0000);
      flush();
   endtask

   task automatic test_reset_mid();
      req_in = 4'b0110;
      step(4);
      chk_d("rm_d", 4'b0110);
      chk_g("rm_offer", 1'b1, 2'd2);
      reset_n = 1'b0;
      step(1);
      chk_d("rm_d0", 4'b0000);
      chk_o("rm_ovf0", 4'b0000);
      checks++;
      if (grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
         errors++;
         $display("FAIL rm_grant got %b/%0d want 0/0", grant_valid, grant_idx);
      end
      reset_n = 1'b1;
      step(2);
      chk_d("rm_lat", 4'b0000);
      step(1);
      chk_d("rm_rereg", 4'b0110);
      step(1);
      chk_g("rm_reoffer", 1'b1, 2'd2);
      flush();
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority_drain();
      test_backpressure();
      test_overflow();
      test_collision();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pending_request_latch.md
# pending_request_latch

Upstream front-end for the 4-input `priority_encoder`. It synchronises four raw request lines and captures their rising edges into a sticky pending vector `D[3:0]`, which drives the encoder's `D`. It consumes the encoder's `Y`/`V` to offer one grant at a time over a valid/ready handshake. It clears each pending bit only once that grant is accepted, so the highest-priority request is served first and no request is lost.

## Interface

- `SYNC_STAGES`, 2: flip-flop stages on each `req_in` bit; legal range 2–3.
- `EDGE_MODE`, 1: 1 = capture rising edges (sticky); 0 = pending bit follows the synchronised level.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_in`  in  4  raw asynchronous request lines; bit 3 has the highest priority.
- `D`  out  4  registered pending vector; connects to `priority_encoder.D`.
- `Y`  in  2  encoder index of the highest set bit of `D` (combinational from `D`).
- `V`  in  1  encoder valid, equal to `|D`.
- `grant_valid`  out  1  a grant is being offered.
- `grant_idx`  out  2  index of the offered request; stable while `grant_valid` is high.
- `grant_ready`  in  1  consumer accepts the grant.
- `overflow`  out  4  sticky per-bit flag: a new edge arrived while that bit was already pending.
- `clr_ovf`  in  1  clears all `overflow` bits.

## Operation

- **Reset.** Reset applies when `reset_n` is low at a clock edge. It clears the synchroniser chain, the edge-history register, `D`, `overflow`, `grant_valid` and `grant_idx` to 0, and sets state to IDLE.
- **Synchroniser and edge detect.**
  - Each bit passes through `SYNC_STAGES` flops to give `s`; the previous `s` is held in `s_d`.
  - `edge = s & ~s_d`.
  - A line held high across reset release registers as one edge afterwards.
- **Pending update, `EDGE_MODE=1`.**
  - Next `D` is `(D & ~clr_mask) | edge`.
  - `clr_mask` is the one-hot of `grant_idx` when a handshake occurs, otherwise 0.
  - Set wins over clear on the same bit.
- **Pending update, `EDGE_MODE=0`.** Next `D` is `s`; `clr_mask` is ignored.
- **Overflow, `EDGE_MODE=1` only.**
  - `overflow[i]` sets when `edge[i]` is 1, `D[i]` is 1, and bit i is not being cleared that cycle.
  - `clr_ovf` clears all bits; a new set on the same cycle wins.
  - In `EDGE_MODE=0`, `overflow` stays 0.
- **Grant FSM.**
  - IDLE: `grant_valid` = 0. If `V` = 1, capture `Y` into `grant_idx` and go to OFFER.
  - OFFER: `grant_valid` = 1 and `grant_idx` is held. If `grant_ready` = 1 (handshake), clear `D[grant_idx]` and go to IDLE. Otherwise stay in OFFER.
  - A higher-priority edge arriving during OFFER does not pre-empt the offer; it wins the next IDLE evaluation.
  - `grant_ready` in IDLE is ignored.
- **Outputs.** All outputs are registered; nothing is combinational from inputs.

## Timing

- `req_in` rises before edge k → `D[i]` = 1 after edge k+`SYNC_STAGES`.
- `D` → `grant_valid`:
  - `V` is seen in the same cycle as `D`.
  - FSM enters OFFER at the next edge, so `grant_valid` = 1 after edge k+`SYNC_STAGES`+1.
- Handshake at edge h → `D[grant_idx]` = 0 and `grant_valid` = 0 after h. The next offer can appear after h+1.
  - Peak throughput is one grant per 2 cycles.
- Empty: `V` = 0 in IDLE → remain in IDLE, `grant_idx` unchanged.
- All four pending: grants are issued in order 3, 2, 1, 0.
- Reset mid-OFFER: `grant_valid` drops after the reset edge and all pending requests are discarded.
- `grant_ready` held high continuously: each offer is accepted on its first OFFER cycle.

## Test plan

- **Single request.** Reset, then `req_in`=4'b0001 from edge 2 onward → `D`=4'b0001 after edge 4; `grant_valid`=1, `grant_idx`=0 after edge 5. With `grant_ready`=1 at edge 6, `D`=0 and `grant_valid`=0 after edge 6.
- **Priority drain.** `req_in` steps 0000→1111 in one cycle, `grant_ready` tied 1 → `grant_idx` sequence 3, 2, 1, 0 on alternate cycles, then `D`=0 and `V`=0.
- **Backpressure.** `req_in`=0010, `grant_ready`=0 for 5 cycles after the offer; meanwhile `req_in` adds bit 3 (→1010) → `grant_idx` stays 1 for all 5 cycles. After accept, the next grant is idx 3.
- **Overflow.** `req_in` bit 2 pulses 0→1→0→1 while `grant_ready`=0 → `overflow`=4'b0100 and `D[2]` stays 1. Then `clr_ovf`=1 → `overflow`=0.
- **Set/clear collision.** A new bit-1 edge lands on the same edge as the handshake for idx 1 → `D[1]` stays 1, `overflow[1]`=0, and a second grant for idx 1 follows.
- **Reset mid-operation.** `reset_n`=0 for one edge while in OFFER with `D`=0110 → `D`, `grant_valid`, `grant_idx` and `overflow` are all 0 after that edge. A still-high `req_in` re-registers after `SYNC_STAGES` cycles.
